fetch_unit: RTL and testbench

Parametrised instruction-fetch stage: holds the program counter, presents it to decode over a valid/ready handshake, and applies branch redirects, halt/resume and call/return. A configurable return-address stack (RAS) supplies return targets. The block sits at the front of the pipeline and drives the instruction-memory address and decode's input register.

---
 rtl/x9_fetch_pkg.sv | 18 +
 rtl/fetch_ras.sv | 75 +++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/x9_fetch_pkg.sv
// rtl/x9_fetch_pkg.sv - shared types and helpers for the fetch stage
//
// Contents:
//   fetch_state_e : fetch FSM states (RUN, HALTED)
//   ras_ptr_w()   : pointer width for a return-address stack of a given depth

package x9_fetch_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// rtl/fetch_ras.sv - circular return-address stack for the fetch stage
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset (empties the stack)
//   push_i, push_data_i    : push a return address
//   pop_i                  : pop the top entry
//   top_o                  : current top entry (valid when !empty_o)
//   empty_o, full_o        : occupancy status
//   overflow_o             : pulse, push while full (oldest entry overwritten)
//   underflow_o            : pulse, pop while empty (no state change)

module fetch_ras
    import x9_fetch_pkg::*;
#(
    parameter int A         = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [A-1:0] push_data_i,
    output logic [A-1:0] top_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         overflow_o,
    output logic         underflow_o
);

    localparam int PW = ras_ptr_w(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [A-1:0]  mem_q [RAS_DEPTH];
    logic [PW-1:0] sp_q, sp_d;      // next write slot; top is sp_q-1
    logic [PW:0]   cnt_q, cnt_d;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == DEPTH_C);
    assign top_o       = mem_q[sp_q - PW'(1)];
    assign overflow_o  = push_i && full_o;
    assign underflow_o = pop_i && !push_i && empty_o;

    // When full, sp_q points at the oldest entry, so a push simply
    // overwrites it and the count saturates at RAS_DEPTH.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_q + PW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, decode handshake, redirect, halt, call/return
//
// Build option: X9_FETCH_RAS_EN enables the return-address stack (fetch_ras).
// Without it, call is ignored, ret behaves as a plain fire and the RAS flags read 0.
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   inst_addr_reset              : PC loaded on reset
//   redirect_valid, redirect_addr: taken branch/jump (flushes regardless of out_ready)
//   call, ret                    : call qualifies a redirect (push PC+1); ret pops on fire
//   halt, resume                 : enter / leave HALTED
//   out_ready, out_valid         : decode handshake for inst_addr_out
//   inst_addr_out                : current PC
//   halted                       : state is HALTED
//   ras_overflow, ras_underflow  : sticky RAS error flags, cleared only by reset

module fetch_unit
    import x9_fetch_pkg::*;
#(
    parameter int A         = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] inst_addr_reset,
    input  logic         redirect_valid,
    input  logic [A-1:0] redirect_addr,
    input  logic         call,
    input  logic         ret,
    input  logic         halt,
    input  logic         resume,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [A-1:0] inst_addr_out,
    output logic         halted,
    output logic         ras_overflow,
    output logic         ras_underflow
);

    fetch_state_e state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [A-1:0] pc_inc;
    logic         fire;

    assign pc_inc        = pc_q + A'(1);
    assign out_valid     = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign inst_addr_out = pc_q;
    assign fire          = out_valid && out_ready;

`ifdef X9_FETCH_RAS_EN
    logic         ras_push, ras_pop;
    logic [A-1:0] ras_top;
    logic         ras_empty, ras_full_unused;
    logic         ras_ovf_pulse, ras_unf_pulse;
    logic         ovf_q, unf_q;

    fetch_ras #(
        .A         (A),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full_unused),
        .overflow_o  (ras_ovf_pulse),
        .underflow_o (ras_unf_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ras_ovf_pulse;
            unf_q <= unf_q | ras_unf_pulse;
        end
    end

    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    logic unused_call;
    assign unused_call   = call;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
`ifdef X9_FETCH_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect_valid) begin
                    pc_d = redirect_addr;
`ifdef X9_FETCH_RAS_EN
                    ras_push = call;
`endif
                end else if (ret && fire) begin
`ifdef X9_FETCH_RAS_EN
                    ras_pop = 1'b1;
                    pc_d    = ras_empty ? pc_inc : ras_top;
`else
                    pc_d    = pc_inc;
`endif
                end else if (fire) begin
                    pc_d = pc_inc;
                end
            end
            HALTED: begin
                // halt wins over a simultaneous resume.
                if (resume && !halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= inst_addr_reset;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    localparam int A         = 8;
    localparam int RAS_DEPTH = 4;

`ifdef X9_FETCH_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [A-1:0] inst_addr_reset;
    logic         redirect_valid;
    logic [A-1:0] redirect_addr;
    logic         call;
    logic         ret;
    logic         halt;
    logic         resume;
    logic         out_ready;
    logic         out_valid;
    logic [A-1:0] inst_addr_out;
    logic         halted;
    logic         ras_overflow;
    logic         ras_underflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .A         (A),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_addr_reset (inst_addr_reset),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .call            (call),
        .ret             (ret),
        .halt            (halt),
        .resume          (resume),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .inst_addr_out   (inst_addr_out),
        .halted          (halted),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        call           = 1'b0;
        ret            = 1'b0;
        halt           = 1'b0;
        resume         = 1'b0;
        out_ready      = 1'b0;
    endtask

    task automatic do_redirect(input logic [A-1:0] tgt, input logic is_call);
        idle_inputs();
        redirect_valid = 1'b1;
        redirect_addr  = tgt;
        call           = is_call;
        tick();
        idle_inputs();
    endtask

    task automatic do_ret();
        idle_inputs();
        ret       = 1'b1;
        out_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    logic [A-1:0] exp_pc;

    initial begin
        idle_inputs();
        inst_addr_reset = 8'h10;

        // Reset then free-running increment.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_pc", inst_addr_out, 8'h10);
        check_val("rst_valid", out_valid, 1'b1);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_ovf", ras_overflow, 1'b0);
        check_val("rst_unf", ras_underflow, 1'b0);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 8'h10 + A'(i);
            check_val("inc_pc", inst_addr_out, exp_pc);
        end

        // Wrap from all-ones.
        inst_addr_reset = 8'hFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_ff", inst_addr_out, 8'hFF);
        out_ready = 1'b1;
        tick();
        check_val("wrap_pc", inst_addr_out, 8'h00);

        // Stall and flush with out_ready low.
        do_redirect(8'h20, 1'b0);
        check_val("redir_20", inst_addr_out, 8'h20);
        tick();
        tick();
        check_val("stall_pc", inst_addr_out, 8'h20);
        check_val("stall_valid", out_valid, 1'b1);
        do_redirect(8'h40, 1'b0);
        check_val("flush_40", inst_addr_out, 8'h40);

        // Call then return.
        do_redirect(8'h05, 1'b0);
        do_redirect(8'h80, 1'b1);
        check_val("call_pc", inst_addr_out, 8'h80);
        do_ret();
        check_val("ret_pc", inst_addr_out, RAS_EN ? 8'h06 : 8'h81);

        // Five calls into a four-deep stack: pushes 0x06+1 style return
        // addresses; the first one must be lost.
        begin
            logic [A-1:0] start;
            start = inst_addr_out;
            for (int i = 0; i < 5; i++) begin
                do_redirect(8'hA0 + A'(i), 1'b1);
                if (i == 3) check_val("ovf_before", ras_overflow, 1'b0);
            end
            check_val("ovf_after", ras_overflow, RAS_EN ? 1'b1 : 1'b0);
            check_val("calls_pc", inst_addr_out, 8'hA4);
            // Returns: A4 -> A4, A3, A2, A1 (RAS) then empty -> PC+1.
            for (int i = 0; i < 4; i++) begin
                do_ret();
                exp_pc = RAS_EN ? (8'hA4 - A'(i)) : (8'hA5 + A'(i));
                check_val("pop_pc", inst_addr_out, exp_pc);
            end
            check_val("unf_before", ras_underflow, 1'b0);
            do_ret();
            check_val("empty_ret_pc", inst_addr_out, RAS_EN ? 8'hA2 : 8'hA9);
            check_val("unf_after", ras_underflow, RAS_EN ? 1'b1 : 1'b0);
            check_val("start_unused", {24'h0, start}, RAS_EN ? 32'h06 : 32'h81);
        end

        // Halt beats a same-cycle redirect.
        do_redirect(8'h30, 1'b0);
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h99;
        out_ready      = 1'b1;
        tick();
        idle_inputs();
        check_val("halt_halted", halted, 1'b1);
        check_val("halt_valid", out_valid, 1'b0);
        check_val("halt_pc", inst_addr_out, 8'h30);
        // Ignored while halted.
        redirect_valid = 1'b1;
        redirect_addr  = 8'h77;
        ret            = 1'b1;
        out_ready      = 1'b1;
        tick();
        idle_inputs();
        check_val("halted_ign_pc", inst_addr_out, 8'h30);
        halt   = 1'b1;
        resume = 1'b1;
        tick();
        idle_inputs();
        check_val("halt_resume", halted, 1'b1);
        resume = 1'b1;
        tick();
        idle_inputs();
        check_val("resume_halted", halted, 1'b0);
        check_val("resume_valid", out_valid, 1'b1);
        check_val("resume_pc", inst_addr_out, 8'h30);

        // Reset while halted with a live RAS entry.
        do_redirect(8'h50, 1'b1);
        halt = 1'b1;
        tick();
        idle_inputs();
        check_val("pre_rst_halted", halted, 1'b1);
        inst_addr_reset = 8'h10;
        reset = 1'b1;
        halt  = 1'b1;
        tick();
        idle_inputs();
        check_val("rst2_pc", inst_addr_out, 8'h10);
        check_val("rst2_valid", out_valid, 1'b1);
        check_val("rst2_halted", halted, 1'b0);
        check_val("rst2_ovf", ras_overflow, 1'b0);
        check_val("rst2_unf", ras_underflow, 1'b0);
        do_ret();
        check_val("rst2_ret_pc", inst_addr_out, 8'h11);
        check_val("rst2_ret_unf", ras_underflow, RAS_EN ? 1'b1 : 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
